// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared widths and FSM state encoding for the instruction fetch controller.
package ifu_fetch_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int PC_WIDTH   = 32;
  localparam int INST_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // Redirect targets are word aligned; the low two bits are ignored.
  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return {pc[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_inst_buf.sv
// Small synchronous FIFO holding fetched {pc, instruction} pairs.
// The head entry is presented combinationally; flush empties the buffer.
module ifu_inst_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot for a same-cycle push even when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage, pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: issues one fetch at a time to instruction
// memory, buffers responses for decode and handles execute-stage redirects.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no request outstanding; may issue a fetch if buffer has room
// ST_WAIT | one request outstanding; its response is written to buffer
// ST_DROP | one request outstanding; its response is discarded
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ifu_req_addr_vld,
  output logic [ADDR_WIDTH-1:0] ifu_req_addr,
  input  logic                  ifu_req_data_vld,
  input  logic [DATA_WIDTH-1:0] ifu_req_data,
  input  logic                  redirect_vld,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  input  logic                  ifu_ready,
  output logic                  ifu_valid,
  output logic [PC_WIDTH-1:0]   ifu_pc,
  output logic [INST_WIDTH-1:0] ifu_inst
);

  localparam int BUF_W = PC_WIDTH + INST_WIDTH;

  fetch_state_e          state;
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic                  req_vld_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;

  logic                  buf_push;
  logic                  buf_pop;
  logic                  buf_full;
  logic                  buf_empty;
  logic [BUF_W-1:0]      buf_head;

  // Only a non-redirected response in WAIT lands in the buffer.
  assign buf_push = (state == ST_WAIT) && ifu_req_data_vld && !redirect_vld;
  assign buf_pop  = ifu_valid && ifu_ready;

  ifu_inst_buf #(
    .WIDTH (BUF_W),
    .DEPTH (BUF_DEPTH)
  ) u_inst_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data ({fetch_pc, INST_WIDTH'(ifu_req_data)}),
    .pop       (buf_pop),
    .flush     (redirect_vld),
    .full      (buf_full),
    .empty     (buf_empty),
    .head      (buf_head)
  );

  assign ifu_valid        = !buf_empty;
  assign ifu_pc           = buf_head[BUF_W-1 -: PC_WIDTH];
  assign ifu_inst         = buf_head[INST_WIDTH-1:0];
  assign ifu_req_addr_vld = req_vld_q;
  assign ifu_req_addr     = req_addr_q;

  // Fetch FSM: request issue, response accounting, redirect and fetch_pc update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      fetch_pc   <= RESET_PC;
      req_vld_q  <= 1'b0;
      req_addr_q <= '0;
    end else begin
      req_vld_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (redirect_vld) begin
            fetch_pc <= align_pc(redirect_pc);
          end else if (!buf_full) begin
            req_vld_q  <= 1'b1;
            req_addr_q <= ADDR_WIDTH'(fetch_pc);
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect_vld) begin
            fetch_pc <= align_pc(redirect_pc);
            state    <= ifu_req_data_vld ? ST_IDLE : ST_DROP;
          end else if (ifu_req_data_vld) begin
            fetch_pc <= fetch_pc + PC_WIDTH'(4);
            state    <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (redirect_vld) begin
            fetch_pc <= align_pc(redirect_pc);
          end
          if (ifu_req_data_vld) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 0, PC of the first fetch after reset.
REQ-002 Parameter: BUF_DEPTH, default 2, number of entries in the instruction buffer (power of two, >= 2).
REQ-003 clk  input  1  single clock for the whole block; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ifu_req_addr_vld  output  1  one-cycle fetch request pulse to instruction memory.
REQ-006 ifu_req_addr  output  ADDR_WIDTH  byte address of the fetch; valid when ifu_req_addr_vld=1.
REQ-007 ifu_req_data_vld  input  1  memory response strobe; responses arrive in order, at least 1 cycle after the request.
REQ-008 ifu_req_data  input  DATA_WIDTH  instruction word; valid when ifu_req_data_vld=1.
REQ-009 redirect_vld  input  1  one-cycle flush and restart request from the execute stage.
REQ-010 redirect_pc  input  PC_WIDTH  new fetch PC; valid when redirect_vld=1; bits [1:0] ignored and treated as 0.
REQ-011 ifu_ready  input  1  decode accepts the current instruction.
REQ-012 ifu_valid  output  1  ifu_pc and ifu_inst hold a valid instruction.
REQ-013 ifu_pc  output  PC_WIDTH  PC of the presented instruction.
REQ-014 ifu_inst  output  INST_WIDTH  presented instruction word.

Function
REQ-015 The FSM SHALL have exactly three states. IDLE: no request outstanding. WAIT: one request outstanding. DROP: one outstanding request whose response is discarded.
REQ-016 IDLE->WAIT SHALL occur when (buffer occupancy + 0) < BUF_DEPTH and redirect_vld=0; the same cycle SHALL pulse ifu_req_addr_vld with ifu_req_addr=fetch_pc.
REQ-017 At most one request SHALL be outstanding; no request SHALL be issued in WAIT or DROP.
REQ-018 In WAIT, ifu_req_data_vld=1 SHALL write {fetch_pc, ifu_req_data} into the buffer, advance fetch_pc by 4, and return to IDLE.
REQ-019 fetch_pc SHALL wrap modulo 2^PC_WIDTH (for PC_WIDTH=32, 0xFFFF_FFFC+4 -> 0x0000_0000).
REQ-020 Back-to-back throughput: a request MAY issue in the cycle after a response is written, if buffer space allows.
REQ-021 The buffer SHALL be a FIFO; ifu_valid = not empty; ifu_pc/ifu_inst = head entry; the head SHALL pop when ifu_valid & ifu_ready.
REQ-022 Buffer full: no request issued; a simultaneous pop and a response write in the same cycle SHALL both take effect.
REQ-023 redirect_vld=1 SHALL flush the buffer and load fetch_pc=redirect_pc the same cycle; ifu_valid SHALL be 0 the next cycle.
REQ-024 A redirect in WAIT without ifu_req_data_vld SHALL move to DROP; a DROP response SHALL be discarded and the FSM SHALL move to IDLE.
REQ-025 A redirect coinciding with ifu_req_data_vld (in WAIT or DROP) SHALL discard that data and go to IDLE.
REQ-026 A redirect in IDLE SHALL suppress the request that cycle; the first request to redirect_pc SHALL issue the following cycle.
REQ-027 A redirect while the FSM is in DROP SHALL reload fetch_pc and keep the FSM in DROP.
REQ-028 ifu_valid & ~ifu_ready SHALL hold ifu_pc/ifu_inst stable until the pop or a redirect.
REQ-029 ifu_req_addr SHALL equal fetch_pc, zero-extended or truncated to ADDR_WIDTH.

Reset
REQ-030 On rst_n=0, asynchronously: FSM=IDLE, fetch_pc=RESET_PC, buffer empty, ifu_valid=0, ifu_req_addr_vld=0, ifu_req_addr=0, ifu_pc=0, ifu_inst=0.
REQ-031 Reset mid-WAIT SHALL abandon the outstanding request. The memory is reset by the same rst_n, so no stale response is expected.
REQ-032 The first request SHALL issue in the first clock after rst_n deasserts.

Structure
REQ-033 ADDR_WIDTH, DATA_WIDTH, PC_WIDTH, INST_WIDTH (all 32) and the FSM state enum SHALL live in the shared core package.
REQ-034 The instruction buffer SHALL be a sub-module named ifu_inst_buf, a parameterized synchronous FIFO with push, pop, flush, full and empty.

Verification
REQ-035 Reset release with an always-ready decoder and a memory with 1-cycle latency returning 0x00000013 -> ifu_pc sequence 0x0, 0x4, 0x8, ..., with ifu_valid=1 from cycle 3 on.
REQ-036 ifu_ready=0 for 10 cycles -> exactly BUF_DEPTH requests issued; ifu_pc=0x0 held stable; no request while the buffer is full.
REQ-037 Redirect to 0x100 while in WAIT, with the response 2 cycles later -> that response is dropped; the next request address is 0x100; no ifu_valid with pc 0x8.
REQ-038 redirect_vld and ifu_req_data_vld in the same cycle, redirect_pc=0x200 -> data discarded; request to 0x200 on the next cycle.
REQ-039 RESET_PC=0xFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-040 rst_n asserted during WAIT -> all outputs are 0 immediately; fetch restarts at RESET_PC after release.
